// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;
    localparam int          RESULT_W  = 14;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_RAND   = 3'd1,
        GO          = 3'd2,
        DONE        = 3'd3,
        FALSE_START = 3'd4,
        TIMEOUT     = 3'd5
    } state_t;
endpackage

// File: rtl/ms_tick_gen.sv
// One-cycle tick every TICK_DIV clocks; clear restarts the period so each trial is tick-aligned.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game: random wait, GO stimulus, measure ms until the player responds.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_EN      = 1,
    parameter int TIMEOUT_MS   = 9999
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_btn,
    input  logic                react_btn,
    output logic                led_go,
    output logic                led_false,
    output logic [RESULT_W-1:0] result_ms,
    output logic                result_valid,
    output logic                timeout,
    output logic                busy,
    output logic [2:0]          state_dbg
);
    localparam logic [RESULT_W-1:0] MIN_DLY = RESULT_W'(MIN_DELAY_MS);
    localparam logic [RESULT_W-1:0] TO_LAST = RESULT_W'(TIMEOUT_MS - 1);
    localparam logic [RESULT_W-1:0] TO_VAL  = RESULT_W'(TIMEOUT_MS);

    state_t              state, state_n;
    logic                start_prev, react_prev, start_edge, react_edge;
    logic [15:0]         lfsr;
    logic                tick, clear;
    logic [RESULT_W-1:0] delay, delay_n, elapsed, elapsed_n, result_n, rand_add;

    assign start_edge = start_btn & ~start_prev;
    assign react_edge = react_btn & ~react_prev;
    assign rand_add   = (RAND_EN != 0) ? {3'b000, lfsr[10:0]} : '0;

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        state_n   = state;
        delay_n   = delay;
        elapsed_n = elapsed;
        result_n  = result_ms;
        clear     = 1'b0;
        case (state)
            IDLE, DONE, FALSE_START, TIMEOUT: begin
                if (start_edge) begin
                    state_n   = WAIT_RAND;
                    delay_n   = MIN_DLY + rand_add;
                    elapsed_n = '0;
                    clear     = 1'b1;
                end
            end
            WAIT_RAND: begin
                // An early press wins over the tick that would have lit GO.
                if (react_edge) begin
                    state_n  = FALSE_START;
                    result_n = '0;
                end else if (tick) begin
                    if (delay <= RESULT_W'(1)) begin
                        state_n   = GO;
                        delay_n   = '0;
                        elapsed_n = '0;
                    end else begin
                        delay_n = delay - 1'b1;
                    end
                end
            end
            GO: begin
                if (react_edge) begin
                    state_n  = DONE;
                    result_n = elapsed;
                end else if (tick) begin
                    if (elapsed >= TO_LAST) begin
                        state_n  = TIMEOUT;
                        result_n = TO_VAL;
                    end else begin
                        elapsed_n = elapsed + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            start_prev   <= 1'b0;
            react_prev   <= 1'b0;
            delay        <= '0;
            elapsed      <= '0;
            result_ms    <= '0;
            led_go       <= 1'b0;
            led_false    <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            lfsr         <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            start_prev   <= start_btn;
            react_prev   <= react_btn;
            delay        <= delay_n;
            elapsed      <= elapsed_n;
            result_ms    <= result_n;
            led_go       <= (state_n == GO);
            led_false    <= (state_n == FALSE_START);
            result_valid <= (state_n == DONE) || (state_n == TIMEOUT);
            timeout      <= (state_n == TIMEOUT);
            busy         <= (state_n == WAIT_RAND) || (state_n == GO);
        end
    end

    assign state_dbg = state;
endmodule
